// File: rtl/vedic_mult_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier: 3 stages, valid/ready stream.
// Ports: clk, rst_n, in_* operand beat, out_* product beat with tag.

module vedic_mul #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o
);

  if (N == 2) begin : g_cell
    logic t1;
    logic t2;
    logic t3;
    logic c1;
    assign t1  = a_i[1] & b_i[0];
    assign t2  = a_i[0] & b_i[1];
    assign t3  = a_i[1] & b_i[1];
    assign c1  = t1 & t2;
    assign p_o = {t3 & c1, t3 ^ c1, t1 ^ t2, a_i[0] & b_i[0]};
  end else begin : g_rec
    localparam int M = N / 2;
    logic [N-1:0] ll;
    logic [N-1:0] hl;
    logic [N-1:0] lh;
    logic [N-1:0] hh;
    logic [N:0]   mid;

    vedic_mul #(.N(M)) u_ll (
      .a_i(a_i[M-1:0]), .b_i(b_i[M-1:0]), .p_o(ll)
    );
    vedic_mul #(.N(M)) u_hl (
      .a_i(a_i[N-1:M]), .b_i(b_i[M-1:0]), .p_o(hl)
    );
    vedic_mul #(.N(M)) u_lh (
      .a_i(a_i[M-1:0]), .b_i(b_i[N-1:M]), .p_o(lh)
    );
    vedic_mul #(.N(M)) u_hh (
      .a_i(a_i[N-1:M]), .b_i(b_i[N-1:M]), .p_o(hh)
    );

    // crosswise sum keeps its carry bit
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign p_o = {hh, ll} + ((2*N)'(mid) << M);
  end

endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  logic adv;

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_neg_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_v_q;
  logic [WIDTH-1:0] s2_ll_q;
  logic [WIDTH-1:0] s2_hl_q;
  logic [WIDTH-1:0] s2_lh_q;
  logic [WIDTH-1:0] s2_hh_q;
  logic             s2_neg_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             out_v_q;
  logic [W2-1:0]    out_p_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] s1_a_d;
  logic [WIDTH-1:0] s1_b_d;
  logic             s1_neg_d;

  logic [WIDTH-1:0] ll_d;
  logic [WIDTH-1:0] hl_d;
  logic [WIDTH-1:0] lh_d;
  logic [WIDTH-1:0] hh_d;

  logic [WIDTH:0]   mid;
  logic [W2-1:0]    mag;
  logic [W2-1:0]    out_p_d;

  // a bubble at the output never blocks
  assign adv      = !out_v_q || out_ready;
  assign in_ready = adv;

  // -2^(W-1) negates to itself, which is the correct magnitude
  assign a_neg    = in_signed & in_a[WIDTH-1];
  assign b_neg    = in_signed & in_b[WIDTH-1];
  assign s1_a_d   = a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign s1_b_d   = b_neg ? (~in_b + WIDTH'(1)) : in_b;
  assign s1_neg_d = a_neg ^ b_neg;

  vedic_mul #(.N(H)) u_ll (
    .a_i(s1_a_q[H-1:0]), .b_i(s1_b_q[H-1:0]), .p_o(ll_d)
  );
  vedic_mul #(.N(H)) u_hl (
    .a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[H-1:0]), .p_o(hl_d)
  );
  vedic_mul #(.N(H)) u_lh (
    .a_i(s1_a_q[H-1:0]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(lh_d)
  );
  vedic_mul #(.N(H)) u_hh (
    .a_i(s1_a_q[WIDTH-1:H]), .b_i(s1_b_q[WIDTH-1:H]), .p_o(hh_d)
  );

  assign mid     = {1'b0, s2_hl_q} + {1'b0, s2_lh_q};
  assign mag     = {s2_hh_q, s2_ll_q} + (W2'(mid) << H);
  assign out_p_d = s2_neg_q ? (~mag + W2'(1)) : mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      out_v_q   <= 1'b0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else if (adv) begin
      s1_v_q    <= in_valid;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_neg_q  <= s1_neg_d;
      s1_tag_q  <= in_tag;
      s2_v_q    <= s1_v_q;
      s2_ll_q   <= ll_d;
      s2_hl_q   <= hl_d;
      s2_lh_q   <= lh_d;
      s2_hh_q   <= hh_d;
      s2_neg_q  <= s1_neg_q;
      s2_tag_q  <= s1_tag_q;
      out_v_q   <= s2_v_q;
      out_p_q   <= out_p_d;
      out_tag_q <= s2_tag_q;
    end
  end

  assign out_valid = out_v_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Testbench for vedic_mult_pipe: WIDTH=8 and WIDTH=16 instances,
// directed corners plus random streams against an a*b reference model.

module tb_vedic_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        v8_iv, v8_ir, v8_is, v8_ov, v8_or;
  logic [7:0]  v8_a, v8_b;
  logic [3:0]  v8_it, v8_ot;
  logic [15:0] v8_p;

  logic        v16_iv, v16_ir, v16_is, v16_ov, v16_or;
  logic [15:0] v16_a, v16_b;
  logic [3:0]  v16_it, v16_ot;
  logic [31:0] v16_p;

  int vectors = 0;
  int miss    = 0;

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8_iv), .in_ready(v8_ir),
    .in_a(v8_a), .in_b(v8_b), .in_signed(v8_is), .in_tag(v8_it),
    .out_valid(v8_ov), .out_ready(v8_or),
    .out_p(v8_p), .out_tag(v8_ot)
  );

  vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16_iv), .in_ready(v16_ir),
    .in_a(v16_a), .in_b(v16_b), .in_signed(v16_is), .in_tag(v16_it),
    .out_valid(v16_ov), .out_ready(v16_or),
    .out_p(v16_p), .out_tag(v16_ot)
  );

  // reference: plain integer product, wrapped to 2*w bits
  function automatic longint ref_mul(longint a, longint b, bit s, int w);
    longint sa = a;
    longint sb = b;
    longint m  = (longint'(1) << (2 * w)) - 1;
    if (s && a[w-1]) sa = a - (longint'(1) << w);
    if (s && b[w-1]) sb = b - (longint'(1) << w);
    return (sa * sb) & m;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (v8_ov !== 1'b0 || v8_p !== 16'h0 || v8_ot !== 4'h0) begin
      miss++;
      $display("FAIL reset8: valid=%b p=%h tag=%h want 0 0000 0",
               v8_ov, v8_p, v8_ot);
    end
    vectors++;
    if (v16_ov !== 1'b0 || v16_p !== 32'h0 || v16_ot !== 4'h0) begin
      miss++;
      $display("FAIL reset16: valid=%b p=%h tag=%h want 0 0 0",
               v16_ov, v16_p, v16_ot);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (v8_ir !== 1'b1 || v16_ir !== 1'b1) begin
      miss++;
      $display("FAIL reset_ready: got %b/%b want 1/1", v8_ir, v16_ir);
    end
  endtask

  task automatic test_unsigned_max();
    v8_or = 1'b1;
    v8_iv = 1'b1; v8_a = 8'hFF; v8_b = 8'hFF;
    v8_is = 1'b0; v8_it = 4'd3;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      v8_iv = 1'b0;
      vectors++;
      if (i < 3 && v8_ov !== 1'b0) begin
        miss++;
        $display("FAIL umax_early: cycle %0d valid=%b want 0", i, v8_ov);
      end else if (i == 3 &&
                   (v8_ov !== 1'b1 || v8_p !== 16'hFE01 || v8_ot !== 4'd3))
      begin
        miss++;
        $display("FAIL umax: valid=%b p=%h tag=%h want 1 fe01 3",
                 v8_ov, v8_p, v8_ot);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed_corners();
    logic [7:0]  ta [4] = '{8'h80, 8'hFD, 8'h00, 8'h80};
    logic [7:0]  tb [4] = '{8'h80, 8'h05, 8'h80, 8'h7F};
    logic [15:0] te [4] = '{16'h4000, 16'hFFF1, 16'h0000, 16'hC080};
    int sent = 0;
    int got  = 0;
    v8_or = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (sent < 4) begin
        v8_iv = 1'b1; v8_a = ta[sent]; v8_b = tb[sent];
        v8_is = 1'b1; v8_it = 4'(sent + 5);
      end else v8_iv = 1'b0;
      @(negedge clk);
      if (v8_iv && v8_ir) sent++;
      if (v8_ov && v8_or) begin
        vectors++;
        if (v8_p !== te[got] || v8_ot !== 4'(got + 5)) begin
          miss++;
          $display("FAIL signed_%0d: p=%h tag=%h want %h %h",
                   got, v8_p, v8_ot, te[got], 4'(got + 5));
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    v8_iv = 1'b0;
    vectors++;
    if (got != 4) begin
      miss++;
      $display("FAIL signed_timeout: got %0d results want 4", got);
    end
  endtask

  task automatic test_back_to_back();
    longint qp[$];
    logic [3:0] qt[$];
    int sent = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    v8_or = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (sent < 8) begin
        v8_iv = 1'b1; v8_a = 8'($urandom); v8_b = 8'($urandom);
        v8_is = 1'($urandom); v8_it = 4'(sent);
      end else v8_iv = 1'b0;
      @(negedge clk);
      if (sent < 8) begin
        vectors++;
        if (v8_ir !== 1'b1) begin
          miss++;
          $display("FAIL b2b_ready: cycle %0d in_ready=%b want 1", c, v8_ir);
        end
      end
      if (v8_iv && v8_ir) begin
        qp.push_back(ref_mul(longint'(v8_a), longint'(v8_b), v8_is, 8));
        qt.push_back(v8_it);
        sent++;
      end
      if (v8_ov && v8_or) begin
        longint ep = qp.pop_front();
        logic [3:0] et = qt.pop_front();
        vectors++;
        if (longint'(v8_p) != ep || v8_ot !== et) begin
          miss++;
          $display("FAIL b2b_data: p=%h tag=%h want %h %h",
                   v8_p, v8_ot, 16'(ep), et);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(posedge clk);
      #1;
    end
    v8_iv = 1'b0;
    vectors++;
    if (got != 8 || last - first != 7) begin
      miss++;
      $display("FAIL b2b_spacing: got %0d span %0d want 8 7",
               got, last - first);
    end
  endtask

  task automatic test_backpressure();
    longint qp[$];
    logic [3:0] qt[$];
    int sent = 0;
    int got = 0;
    bit stalled = 1'b0;
    logic [15:0] hp = '0;
    logic [3:0] ht = '0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      v8_or = !(c >= 6 && c <= 10);
      if (sent < 16) begin
        v8_iv = 1'b1; v8_a = 8'($urandom); v8_b = 8'($urandom);
        v8_is = 1'($urandom); v8_it = 4'(sent);
      end else v8_iv = 1'b0;
      @(negedge clk);
      vectors++;
      if (v8_ir !== (!v8_ov || v8_or)) begin
        miss++;
        $display("FAIL bp_ready: cycle %0d in_ready=%b valid=%b oready=%b",
                 c, v8_ir, v8_ov, v8_or);
      end
      if (stalled) begin
        vectors++;
        if (v8_ov !== 1'b1 || v8_p !== hp || v8_ot !== ht) begin
          miss++;
          $display("FAIL bp_hold: valid=%b p=%h tag=%h want 1 %h %h",
                   v8_ov, v8_p, v8_ot, hp, ht);
        end
      end
      stalled = v8_ov && !v8_or;
      hp = v8_p;
      ht = v8_ot;
      if (v8_iv && v8_ir) begin
        qp.push_back(ref_mul(longint'(v8_a), longint'(v8_b), v8_is, 8));
        qt.push_back(v8_it);
        sent++;
      end
      if (v8_ov && v8_or) begin
        longint ep = qp.pop_front();
        logic [3:0] et = qt.pop_front();
        vectors++;
        if (longint'(v8_p) != ep || v8_ot !== et) begin
          miss++;
          $display("FAIL bp_data: p=%h tag=%h want %h %h",
                   v8_p, v8_ot, 16'(ep), et);
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    v8_iv = 1'b0;
    v8_or = 1'b1;
    vectors++;
    if (got != 16 || qp.size() != 0) begin
      miss++;
      $display("FAIL bp_count: got %0d pending %0d want 16 0",
               got, qp.size());
    end
  endtask

  task automatic test_reset_inflight();
    longint ep;
    int got = 0;
    v8_or = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v8_iv = 1'b1; v8_a = 8'($urandom); v8_b = 8'($urandom);
      v8_is = 1'($urandom); v8_it = 4'(i + 1);
      @(posedge clk);
      #1;
    end
    v8_iv = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v8_or = 1'b1;
    vectors++;
    if (v8_ov !== 1'b0 || v8_p !== 16'h0 || v8_ot !== 4'h0) begin
      miss++;
      $display("FAIL rst_flight: valid=%b p=%h tag=%h want 0 0000 0",
               v8_ov, v8_p, v8_ot);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (v8_ov !== 1'b0) begin
        miss++;
        $display("FAIL rst_stale: cycle %0d valid=%b want 0", c, v8_ov);
      end
    end
    @(posedge clk);
    #1;
    v8_iv = 1'b1; v8_a = 8'h12; v8_b = 8'h34; v8_is = 1'b0; v8_it = 4'hA;
    ep = ref_mul(64'h12, 64'h34, 1'b0, 8);
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (v8_ov && v8_or) begin
        vectors++;
        if (longint'(v8_p) != ep || v8_ot !== 4'hA) begin
          miss++;
          $display("FAIL rst_first: p=%h tag=%h want %h a",
                   v8_p, v8_ot, 16'(ep));
        end
        got++;
      end
      @(posedge clk);
      #1;
      v8_iv = 1'b0;
    end
    vectors++;
    if (got != 1) begin
      miss++;
      $display("FAIL rst_first_timeout: got %0d want 1", got);
    end
  endtask

  task automatic test_w16_random();
    localparam int N = 10001;
    longint qp[$];
    logic [3:0] qt[$];
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 60000 && got < N; c++) begin
      v16_or = ($urandom_range(3) != 0);
      if (sent == 0) begin
        v16_iv = 1'b1; v16_a = 16'hFFFF; v16_b = 16'hFFFF;
        v16_is = 1'b0; v16_it = 4'h7;
      end else if (sent < N) begin
        v16_iv = ($urandom_range(4) != 0);
        v16_a = 16'($urandom); v16_b = 16'($urandom);
        v16_is = 1'($urandom); v16_it = 4'($urandom);
      end else v16_iv = 1'b0;
      @(negedge clk);
      if (v16_iv && v16_ir) begin
        if (sent == 0) qp.push_back(64'hFFFE0001);
        else qp.push_back(ref_mul(longint'(v16_a), longint'(v16_b),
                                  v16_is, 16));
        qt.push_back(v16_it);
        sent++;
      end
      if (v16_ov && v16_or) begin
        longint ep = qp.pop_front();
        logic [3:0] et = qt.pop_front();
        vectors++;
        if (longint'(v16_p) != ep || v16_ot !== et) begin
          miss++;
          $display("FAIL w16_%0d: p=%h tag=%h want %h %h",
                   got, v16_p, v16_ot, 32'(ep), et);
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    v16_iv = 1'b0;
    vectors++;
    if (got != N) begin
      miss++;
      $display("FAIL w16_timeout: got %0d want %0d", got, N);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v8_iv = 1'b0; v8_a = '0; v8_b = '0; v8_is = 1'b0; v8_it = '0;
    v8_or = 1'b1;
    v16_iv = 1'b0; v16_a = '0; v16_b = '0; v16_is = 1'b0; v16_it = '0;
    v16_or = 1'b1;
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_w16_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
